// File: rtl/regfile_pkg.sv
// Types and constants shared by the register-file address decoder and the
// round-robin request encoder.
package regfile_pkg;

    localparam int REG_N     = 8;
    localparam int REG_IDX_W = $clog2(REG_N);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [REG_N-1:0]     reg_vec_t;

    // Output stage of the encoder: EMPTY holds nothing, FULL holds an index.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Rotate a request vector right so that bit `amt` lands at bit 0.
    function automatic reg_vec_t rotr_vec(input reg_vec_t v, input reg_idx_t amt);
        logic [2*REG_N-1:0] dbl;
        dbl = {v, v} >> amt;
        return dbl[REG_N-1:0];
    endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping from the top bit back to bit 0.
module rr_prio_select
    import regfile_pkg::*;
(
    input  reg_vec_t req,
    input  reg_idx_t ptr,
    output reg_idx_t sel,
    output logic     any
);

    reg_vec_t rot;
    reg_idx_t off;

    // Rotating puts ptr at bit 0, so a plain lowest-bit-first search gives
    // the offset from ptr; adding ptr back wraps naturally in 3 bits.
    always_comb begin
        rot = rotr_vec(req, ptr);
        off = '0;
        for (int i = REG_N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = reg_idx_t'(i);
            end
        end
        sel = off + ptr;
        any = |req;
    end

endmodule

// File: rtl/enc_8to3_rr.sv
// Round-robin 8-to-3 encoder feeding a single-entry valid/ready output
// register toward the register-file write port.
module enc_8to3_rr
    import regfile_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx
);

    // Handshake: an index transfers on any rising edge where out_valid and
    // out_ready are both high; out_idx is held stable while out_valid is high
    // and out_ready is low. grant pulses only in the cycle a winner is loaded.

    out_state_e state_q, state_d;
    reg_idx_t   ptr_q, ptr_d;
    reg_idx_t   idx_q, idx_d;

    reg_idx_t   sel;
    logic       any;
    logic       load;

    rr_prio_select u_sel (
        .req (reg_vec_t'(req)),
        .ptr (ptr_q),
        .sel (sel),
        .any (any)
    );

    assign load = any && ((state_q == OUT_EMPTY) || out_ready);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        if (load) begin
            state_d = OUT_FULL;
            idx_d   = sel;
            ptr_d   = sel + reg_idx_t'(1);
        end else if ((state_q == OUT_FULL) && out_ready) begin
            state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OUT_EMPTY;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    // Reset wins over load, so no acknowledge may escape in a reset cycle.
    assign grant     = (load && !reset) ? (N'(1) << sel) : '0;
    assign out_valid = (state_q == OUT_FULL);
    assign out_idx   = idx_q;

endmodule
